// File: rtl/tdd_sched.sv
// tdd_sched: TDD frame scheduler. Counts samples within a frame, raises
// tx_en / rx_en for the configured windows and pulses frame_sync at each
// frame start. Optional one-frame length adjustment is compiled in when the
// macro TDD_ADJ_EN is defined; without it adj_req/frame_adj are ignored.
module tdd_sched #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ce,
    input  logic [CNT_W-1:0] frame_len,
    input  logic [CNT_W-1:0] tstart,
    input  logic [CNT_W-1:0] tend,
    input  logic [CNT_W-1:0] rstart,
    input  logic [CNT_W-1:0] rend,
    input  logic             adj_req,
    input  logic [CNT_W-1:0] frame_adj,
    output logic             tx_en,
    output logic             rx_en,
    output logic             frame_sync,
    output logic [CNT_W-1:0] cnt,
    output logic [15:0]      frame_num,
    output logic             adj_pending,
    output logic             overlap_err
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic             start;      // IDLE -> RUN this cycle
    logic             run;        // in RUN and staying there
    logic             wrap;       // last sample of the frame consumed
    logic [CNT_W-1:0] shadow_len;
    logic [CNT_W-1:0] last;
    logic [CNT_W-1:0] len_load;   // frame_len with 0 promoted to 1
    logic [CNT_W-1:0] next_len;   // length loaded at the coming wrap
    logic             tx_hit, rx_hit;

    // Half-open window test; start>end wraps around the frame end,
    // start==end is an empty window.
    function automatic logic in_win(input logic [CNT_W-1:0] c,
                                    input logic [CNT_W-1:0] s,
                                    input logic [CNT_W-1:0] e);
        logic r;
        if (s < e)      r = (c >= s) && (c < e);
        else if (s > e) r = (c >= s) || (c < e);
        else            r = 1'b0;
        return r;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: en alone decides; leaving RUN does not wait for frame end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en)  state_nxt = RUN;
            RUN:     if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM-derived control strobes and window hits
    always_comb begin
        start    = (state == IDLE) && en;
        run      = (state == RUN) && en;
        last     = shadow_len - 1'b1;
        wrap     = run && ce && (cnt == last);
        len_load = (frame_len == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : frame_len;
        tx_hit   = in_win(cnt, tstart, tend);
        rx_hit   = in_win(cnt, rstart, rend);
    end

`ifdef TDD_ADJ_EN
    logic [CNT_W-1:0]        adj_val;
    logic                    adj_in_frame;  // the adjusted frame is running
    logic signed [CNT_W+1:0] adj_sum;
    logic [CNT_W-1:0]        adj_len;

    // Adjusted length = current shadow + signed offset, clamped to [1, max]
    always_comb begin
        adj_sum = $signed({2'b00, shadow_len}) + $signed({{2{adj_val[CNT_W-1]}}, adj_val});
        if (adj_sum < $signed({{(CNT_W+1){1'b0}}, 1'b1}))
            adj_len = {{(CNT_W-1){1'b0}}, 1'b1};
        else if (adj_sum > $signed({2'b00, {CNT_W{1'b1}}}))
            adj_len = {CNT_W{1'b1}};
        else
            adj_len = adj_sum[CNT_W-1:0];
        next_len = (adj_pending && !adj_in_frame) ? adj_len : len_load;
    end

    // Accept one adjustment, apply it to the frame after the next wrap,
    // retire it at the wrap that ends that frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adj_val      <= '0;
            adj_pending  <= 1'b0;
            adj_in_frame <= 1'b0;
        end else if (!run) begin
            adj_pending  <= 1'b0;
            adj_in_frame <= 1'b0;
        end else if (wrap && adj_pending) begin
            if (!adj_in_frame) begin
                adj_in_frame <= 1'b1;
            end else begin
                adj_pending  <= 1'b0;
                adj_in_frame <= 1'b0;
            end
        end else if (adj_req && !adj_pending) begin
            adj_val     <= frame_adj;
            adj_pending <= 1'b1;
        end
    end
`else
    logic unused_adj;

    assign next_len    = len_load;
    assign adj_pending = 1'b0;
    assign unused_adj  = ^{adj_req, frame_adj};
`endif

    // Sample counter, frame length shadow, frame_sync pulse and frame number
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            shadow_len <= {{(CNT_W-1){1'b0}}, 1'b1};
            frame_sync <= 1'b0;
            frame_num  <= '0;
        end else if (start) begin
            cnt        <= '0;
            shadow_len <= len_load;
            frame_sync <= 1'b1;
        end else if (run) begin
            frame_sync <= 1'b0;
            if (wrap) begin
                cnt        <= '0;
                shadow_len <= next_len;
                frame_sync <= 1'b1;
                frame_num  <= frame_num + 16'd1;
            end else if (ce) begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt        <= '0;
            frame_sync <= 1'b0;
        end
    end

    // Registered window enables; TX wins a collision and flags it stickily
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_en       <= 1'b0;
            rx_en       <= 1'b0;
            overlap_err <= 1'b0;
        end else if (run) begin
            tx_en <= tx_hit;
            rx_en <= rx_hit && !tx_hit;
            if (tx_hit && rx_hit) overlap_err <= 1'b1;
        end else begin
            tx_en <= 1'b0;
            rx_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tdd_sched.sv
// tb_tdd_sched: directed self-checking bench for tdd_sched (CNT_W=8).
// Adjustment expectations follow TDD_ADJ_EN the same way the design does.
module tb_tdd_sched;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n, en, ce, adj_req;
    logic [CNT_W-1:0] frame_len, tstart, tend, rstart, rend, frame_adj;
    logic             tx_en, rx_en, frame_sync, adj_pending, overlap_err;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      frame_num;

    int n_chk = 0;
    int n_err = 0;

    tdd_sched #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ce(ce),
        .frame_len(frame_len), .tstart(tstart), .tend(tend),
        .rstart(rstart), .rend(rend), .adj_req(adj_req), .frame_adj(frame_adj),
        .tx_en(tx_en), .rx_en(rx_en), .frame_sync(frame_sync), .cnt(cnt),
        .frame_num(frame_num), .adj_pending(adj_pending), .overlap_err(overlap_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pc, e, fn;
        logic efs;
        int fs_at[$];
        int exp_fs[$];

        rst_n = 1'b0; en = 1'b0; ce = 1'b1; adj_req = 1'b0; frame_adj = '0;
        frame_len = 8'd10; tstart = 8'd2; tend = 8'd5; rstart = 8'd6; rend = 8'd9;
        repeat (2) tick();
        chk("rst_cnt", cnt, 0);
        chk("rst_tx", tx_en, 0);
        chk("rst_rx", rx_en, 0);
        chk("rst_fs", frame_sync, 0);
        chk("rst_fnum", frame_num, 0);
        chk("rst_pend", adj_pending, 0);
        chk("rst_ovl", overlap_err, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_cnt", cnt, 0);

        // Basic frame: windows [2,5) and [6,9), frame length 10
        en = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            pc = k - 2;
            chk("a_cnt", cnt, (k - 1) % 10);
            chk("a_fs", frame_sync, ((k - 1) % 10) == 0);
            chk("a_fnum", frame_num, (k - 1) / 10);
            chk("a_tx", tx_en, (k >= 2) && (pc % 10 >= 2) && (pc % 10 < 5));
            chk("a_rx", rx_en, (k >= 2) && (pc % 10 >= 6) && (pc % 10 < 9));
        end
        chk("a_ovl", overlap_err, 0);
        en = 1'b0;          // cnt is 4 here, tx would otherwise be 1
        tick();
        chk("a_off_cnt", cnt, 0);
        chk("a_off_tx", tx_en, 0);
        chk("a_off_fnum", frame_num, 2);

        // Wrapping TX window 8..1, empty RX window
        tstart = 8'd8; tend = 8'd2; rstart = 8'd3; rend = 8'd3;
        en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            pc = (k - 2) % 10;
            if (k == 1) chk("b_fnum_entry", frame_num, 2);
            chk("b_tx", tx_en, (k >= 2) && (pc >= 8 || pc < 2));
            chk("b_rx", rx_en, 0);
        end
        chk("b_fnum", frame_num, 3);
        en = 1'b0;
        tick();

        // Overlapping windows at cnt=4
        tstart = 8'd0; tend = 8'd5; rstart = 8'd4; rend = 8'd8;
        en = 1'b1;
        repeat (5) tick();
        chk("c_cnt4", cnt, 4);
        chk("c_ovl_before", overlap_err, 0);
        chk("c_rx_before", rx_en, 0);
        tick();
        chk("c_tx_ovl", tx_en, 1);
        chk("c_rx_ovl", rx_en, 0);
        chk("c_ovl", overlap_err, 1);
        rstart = 8'd6;
        repeat (10) tick();
        chk("c_ovl_sticky", overlap_err, 1);
        en = 1'b0;
        tick();

        // en drop at cnt=5, then restart
        tstart = 8'd2; tend = 8'd7; rstart = 8'd0; rend = 8'd0;
        en = 1'b1;
        for (int i = 0; i < 50 && cnt != 5; i++) tick();
        chk("d_cnt5", cnt, 5);
        chk("d_tx_on", tx_en, 1);
        fn = frame_num;
        en = 1'b0;
        tick();
        chk("d_off_cnt", cnt, 0);
        chk("d_off_tx", tx_en, 0);
        chk("d_off_rx", rx_en, 0);
        en = 1'b1;
        tick();
        chk("d_re_cnt", cnt, 0);
        chk("d_re_fs", frame_sync, 1);
        chk("d_re_fnum", frame_num, fn);
        repeat (5) tick();
        chk("d_cnt5b", cnt, 5);
        rst_n = 1'b0;
        #1;
        chk("d_rst_cnt", cnt, 0);
        chk("d_rst_tx", tx_en, 0);
        chk("d_rst_fnum", frame_num, 0);
        chk("d_rst_ovl", overlap_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("d_rec_cnt", cnt, 0);
        chk("d_rec_fs", frame_sync, 1);
        chk("d_rec_fnum", frame_num, 0);
        tick();
        chk("d_rec_cnt1", cnt, 1);
        chk("d_rec_fs0", frame_sync, 0);
        en = 1'b0;
        tick();

        // Sparse ce (every 4th cycle), frame length 3
        frame_len = 8'd3;
        en = 1'b1;
        tick();
        chk("e_entry_fs", frame_sync, 1);
        e = 0;
        for (int i = 0; i < 24; i++) begin
            ce = (i % 4) == 0;
            efs = 1'b0;
            if (ce) begin
                if (e == 2) begin e = 0; efs = 1'b1; end
                else e++;
            end
            tick();
            chk("e_cnt", cnt, e);
            chk("e_fs", frame_sync, efs);
        end
        ce = 1'b1;
        en = 1'b0;
        tick();

        // frame_len=0 behaves as 1: sync on every sample
        frame_len = 8'd0;
        en = 1'b1;
        tick();
        fn = frame_num;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("f_cnt", cnt, 0);
            chk("f_fs", frame_sync, 1);
            chk("f_fnum", frame_num, (fn + i) & 16'hFFFF);
        end
        en = 1'b0;
        tick();

        // Frame length adjustment (-3), second request while pending
        frame_len = 8'd10;
        en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            adj_req = (k == 5) || (k == 15);
            frame_adj = (k == 5) ? 8'hFD : 8'h05;
            tick();
            adj_req = 1'b0;
            if (frame_sync) fs_at.push_back(k);
`ifdef TDD_ADJ_EN
            if (k == 5)  chk("g_pend_set", adj_pending, 1);
            if (k == 17) chk("g_pend_hold", adj_pending, 1);
            if (k == 18) chk("g_pend_clr", adj_pending, 0);
`else
            if (k == 5)  chk("g_pend_tied", adj_pending, 0);
`endif
        end
`ifdef TDD_ADJ_EN
        exp_fs = '{1, 11, 18, 28, 38};
`else
        exp_fs = '{1, 11, 21, 31};
`endif
        chk("g_nsync", fs_at.size(), exp_fs.size());
        for (int i = 0; i < exp_fs.size() && i < fs_at.size(); i++)
            chk("g_sync_at", fs_at[i], exp_fs[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/tdd_sched.md
TDD_SCHED -- requirements
Module: tdd_sched

Interface
REQ-001 Parameter CNT_W, default 24: width of the sample counter and of all timing inputs.
REQ-002 clk  input  1  sample clock, rising edge; the single clock of the block.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 en  input  1  TDD mode enable; high = run, low = idle.
REQ-005 ce  input  1  sample strobe; the counter advances only on cycles with ce=1.
REQ-006 frame_len  input  CNT_W  nominal frame length in samples.
REQ-007 tstart, tend  input  CNT_W each  TX window bounds [tstart, tend).
REQ-008 rstart, rend  input  CNT_W each  RX window bounds [rstart, rend).
REQ-009 adj_req  input  1  single-cycle request for a one-frame length adjustment.
REQ-010 frame_adj  input  CNT_W  signed two's-complement adjustment, sampled with adj_req.
REQ-011 tx_en  output  1  TX window active; drives the output-stream enable.
REQ-012 rx_en  output  1  RX window active; drives the input-stream enable.
REQ-013 frame_sync  output  1  one-cycle pulse at each frame start.
REQ-014 cnt  output  CNT_W  current sample index within the frame.
REQ-015 frame_num  output  16  frame counter; wraps 0xFFFF -> 0.
REQ-016 adj_pending  output  1  an adjustment is accepted and not yet completed.
REQ-017 overlap_err  output  1  sticky flag: TX and RX windows collided.

Function
REQ-018 State machine: IDLE, RUN. IDLE -> RUN on the first cycle with en=1. RUN -> IDLE on any cycle with en=0, without waiting for the frame end.
REQ-019 On entry to RUN: cnt=0, frame_sync=1 for one cycle, frame_len shadow loaded, frame_num unchanged.
REQ-020 In RUN with ce=1: cnt increments. When cnt equals last, cnt goes to 0, frame_sync pulses on that cycle, and frame_num increments.
REQ-021 last = shadow_len-1. shadow_len is reloaded from frame_len only at frame wrap. A frame_len of 0 is treated as 1, so cnt stays 0 and frame_sync pulses on every ce.
REQ-022 Window membership: if start<end, start<=cnt<end. If start>end, the window wraps: cnt>=start or cnt<end. If start==end, the window is empty.
REQ-023 tx_en and rx_en are registered with 1-cycle latency after cnt. In IDLE both are 0.
REQ-024 If both windows contain the same cnt, tx_en=1, rx_en=0, and overlap_err is set. overlap_err clears only on reset.
REQ-025 cnt holds its value on cycles with ce=0. The window outputs follow the held cnt.
REQ-026 Leaving RUN forces cnt=0 and tx_en=rx_en=0 on the next cycle, and clears adj_pending.

Reset
REQ-027 While rst_n=0: state=IDLE; cnt, frame_num, tx_en, rx_en, frame_sync, adj_pending, overlap_err all 0.
REQ-028 Reset in RUN aborts the frame immediately. After rst_n deasserts, RUN restarts at cnt=0 only if en=1.

Configuration
REQ-029 Macro TDD_ADJ_EN defined: adj_req in RUN with adj_pending=0 latches frame_adj and sets adj_pending.
- The frame that follows the next wrap has length shadow_len+frame_adj, clamped to a minimum of 1 and a maximum of 2^CNT_W-1.
- adj_pending clears at the wrap that ends the adjusted frame.
- adj_req while adj_pending=1 or in IDLE is ignored.
REQ-030 Macro TDD_ADJ_EN undefined: adj_req and frame_adj are ignored, adj_pending is tied to 0, and no adjustment logic is synthesized.

Verification
REQ-031 frame_len=10, tstart=2, tend=5, rstart=6, rend=9, ce=1 always, en rises -> cnt 0..9 repeats; tx_en high for 3 cycles starting 1 cycle after cnt=2; rx_en high for 3 cycles starting 1 cycle after cnt=6; frame_sync every 10 cycles.
REQ-032 tstart=8, tend=2, frame_len=10 -> tx_en covers cnt 8,9,0,1 across the wrap.
REQ-033 tstart=0, tend=5, rstart=4, rend=8 -> at cnt=4 tx_en=1, rx_en=0; overlap_err=1 and stays 1 after the windows are fixed.
REQ-034 TDD_ADJ_EN defined, frame_len=10, adj_req with frame_adj=-3 mid-frame -> current frame is 10 samples, next frame is 7 samples, following frame is 10; adj_pending drops at the 7-sample frame's wrap. A second adj_req while pending has no effect.
REQ-035 ce asserted every 4th cycle -> cnt advances once per 4 cycles; frame_sync width is still 1 cycle.
REQ-036 en or rst_n dropped at cnt=5 -> tx_en=rx_en=0 next cycle; with en=1 after recovery, the next frame_sync is at cnt=0 and frame_num continues (it resets only on rst_n).
